// File: rtl/axi_read_arbiter.sv
// axi_read_arbiter: shares one AXI read slave between two masters (M0, M1).
// Exactly one burst is outstanding at a time. The grant index is carried in the
// upper bits of the slave-side ID so that returning beats can be validated.
module axi_read_arbiter #(
    parameter int ID_BITS   = 4,
    parameter int IDS_BITS  = 8,
    parameter int ADDR_BITS = 32,
    parameter int DATA_BITS = 32,
    parameter int LEN_BITS  = 4,
    parameter int SIZE_BITS = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    // M0 AR
    input  logic [ID_BITS-1:0]   ARID_M0,
    input  logic [ADDR_BITS-1:0] ARADDR_M0,
    input  logic [LEN_BITS-1:0]  ARLEN_M0,
    input  logic [SIZE_BITS-1:0] ARSIZE_M0,
    input  logic [1:0]           ARBURST_M0,
    input  logic                 ARVALID_M0,
    output logic                 ARREADY_M0,
    // M0 R
    output logic [ID_BITS-1:0]   RID_M0,
    output logic [DATA_BITS-1:0] RDATA_M0,
    output logic [1:0]           RRESP_M0,
    output logic                 RLAST_M0,
    output logic                 RVALID_M0,
    input  logic                 RREADY_M0,
    // M1 AR
    input  logic [ID_BITS-1:0]   ARID_M1,
    input  logic [ADDR_BITS-1:0] ARADDR_M1,
    input  logic [LEN_BITS-1:0]  ARLEN_M1,
    input  logic [SIZE_BITS-1:0] ARSIZE_M1,
    input  logic [1:0]           ARBURST_M1,
    input  logic                 ARVALID_M1,
    output logic                 ARREADY_M1,
    // M1 R
    output logic [ID_BITS-1:0]   RID_M1,
    output logic [DATA_BITS-1:0] RDATA_M1,
    output logic [1:0]           RRESP_M1,
    output logic                 RLAST_M1,
    output logic                 RVALID_M1,
    input  logic                 RREADY_M1,
    // Slave AR
    output logic [IDS_BITS-1:0]  ARID_S,
    output logic [ADDR_BITS-1:0] ARADDR_S,
    output logic [LEN_BITS-1:0]  ARLEN_S,
    output logic [SIZE_BITS-1:0] ARSIZE_S,
    output logic [1:0]           ARBURST_S,
    output logic                 ARVALID_S,
    input  logic                 ARREADY_S,
    // Slave R
    input  logic [IDS_BITS-1:0]  RID_S,
    input  logic [DATA_BITS-1:0] RDATA_S,
    input  logic [1:0]           RRESP_S,
    input  logic                 RLAST_S,
    input  logic                 RVALID_S,
    output logic                 RREADY_S
);

    localparam int TAG_BITS = IDS_BITS - ID_BITS;

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t                state_q, state_d;
    logic                  prio_q, prio_d;
    logic                  g_q;
    logic                  load;
    logic [ID_BITS-1:0]    arid_q;
    logic [ADDR_BITS-1:0]  araddr_q;
    logic [LEN_BITS-1:0]   arlen_q;
    logic [SIZE_BITS-1:0]  arsize_q;
    logic [1:0]            arburst_q;

    logic                  grant_m0;
    logic                  grant_m1;
    logic [TAG_BITS-1:0]   g_tag;
    logic                  tag_ok;
    logic                  last_fire;

    // Priority decides only when both masters request in the same cycle.
    assign grant_m0  = ARVALID_M0 && (!ARVALID_M1 || !prio_q);
    assign grant_m1  = ARVALID_M1 && !grant_m0;
    assign g_tag     = TAG_BITS'(g_q);
    assign tag_ok    = (RID_S[IDS_BITS-1:ID_BITS] == g_tag);
    assign last_fire = RVALID_S && (g_q ? RREADY_M1 : RREADY_M0) && RLAST_S;

    // Registered AR fields always feed the slave; ARVALID_S qualifies them.
    assign ARID_S    = {g_tag, arid_q};
    assign ARADDR_S  = araddr_q;
    assign ARLEN_S   = arlen_q;
    assign ARSIZE_S  = arsize_q;
    assign ARBURST_S = arburst_q;

    // State and priority register; reset abandons any burst in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            prio_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
        end
    end

    // Capture the granted master's AR fields and index on the IDLE handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            g_q       <= 1'b0;
            arid_q    <= '0;
            araddr_q  <= '0;
            arlen_q   <= '0;
            arsize_q  <= '0;
            arburst_q <= '0;
        end else if (load) begin
            g_q       <= grant_m1;
            arid_q    <= grant_m1 ? ARID_M1    : ARID_M0;
            araddr_q  <= grant_m1 ? ARADDR_M1  : ARADDR_M0;
            arlen_q   <= grant_m1 ? ARLEN_M1   : ARLEN_M0;
            arsize_q  <= grant_m1 ? ARSIZE_M1  : ARSIZE_M0;
            arburst_q <= grant_m1 ? ARBURST_M1 : ARBURST_M0;
        end
    end

    // Next-state logic plus the combinational AR/R routing for each state.
    always_comb begin
        state_d    = state_q;
        prio_d     = prio_q;
        load       = 1'b0;
        ARREADY_M0 = 1'b0;
        ARREADY_M1 = 1'b0;
        ARVALID_S  = 1'b0;
        RREADY_S   = 1'b0;
        RID_M0     = '0;
        RDATA_M0   = '0;
        RRESP_M0   = 2'b00;
        RLAST_M0   = 1'b0;
        RVALID_M0  = 1'b0;
        RID_M1     = '0;
        RDATA_M1   = '0;
        RRESP_M1   = 2'b00;
        RLAST_M1   = 1'b0;
        RVALID_M1  = 1'b0;
        case (state_q)
            IDLE: begin
                // ARREADY is suppressed while reset is held.
                if (!rst && (grant_m0 || grant_m1)) begin
                    ARREADY_M0 = grant_m0;
                    ARREADY_M1 = grant_m1;
                    load       = 1'b1;
                    state_d    = ADDR;
                end
            end
            ADDR: begin
                ARVALID_S = 1'b1;
                if (ARREADY_S) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                // A beat tagged for the other master is still passed on, as DECERR.
                if (!g_q) begin
                    RVALID_M0 = RVALID_S;
                    RREADY_S  = RREADY_M0;
                    RDATA_M0  = RDATA_S;
                    RLAST_M0  = RLAST_S;
                    RID_M0    = RID_S[ID_BITS-1:0];
                    RRESP_M0  = tag_ok ? RRESP_S : 2'b11;
                end else begin
                    RVALID_M1 = RVALID_S;
                    RREADY_S  = RREADY_M1;
                    RDATA_M1  = RDATA_S;
                    RLAST_M1  = RLAST_S;
                    RID_M1    = RID_S[ID_BITS-1:0];
                    RRESP_M1  = tag_ok ? RRESP_S : 2'b11;
                end
                if (last_fire) begin
                    state_d = IDLE;
                    prio_d  = !g_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Testbench for axi_read_arbiter: scenario tasks with an R-channel scoreboard.
module tb_axi_read_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  ARID_M0, ARID_M1;
    logic [31:0] ARADDR_M0, ARADDR_M1;
    logic [3:0]  ARLEN_M0, ARLEN_M1;
    logic [2:0]  ARSIZE_M0, ARSIZE_M1;
    logic [1:0]  ARBURST_M0, ARBURST_M1;
    logic        ARVALID_M0, ARVALID_M1;
    logic        ARREADY_M0, ARREADY_M1;
    logic [3:0]  RID_M0, RID_M1;
    logic [31:0] RDATA_M0, RDATA_M1;
    logic [1:0]  RRESP_M0, RRESP_M1;
    logic        RLAST_M0, RLAST_M1;
    logic        RVALID_M0, RVALID_M1;
    logic        RREADY_M0, RREADY_M1;
    logic [7:0]  ARID_S;
    logic [31:0] ARADDR_S;
    logic [3:0]  ARLEN_S;
    logic [2:0]  ARSIZE_S;
    logic [1:0]  ARBURST_S;
    logic        ARVALID_S;
    logic        ARREADY_S;
    logic [7:0]  RID_S;
    logic [31:0] RDATA_S;
    logic [1:0]  RRESP_S;
    logic        RLAST_S;
    logic        RVALID_S;
    logic        RREADY_S;

    typedef struct packed {
        logic        m;
        logic [31:0] data;
        logic [3:0]  id;
        logic [1:0]  resp;
        logic        last;
    } beat_t;

    beat_t q[$];
    int    checks = 0;
    int    errors = 0;

    axi_read_arbiter dut (
        .clk(clk), .rst(rst),
        .ARID_M0(ARID_M0), .ARADDR_M0(ARADDR_M0), .ARLEN_M0(ARLEN_M0),
        .ARSIZE_M0(ARSIZE_M0), .ARBURST_M0(ARBURST_M0), .ARVALID_M0(ARVALID_M0),
        .ARREADY_M0(ARREADY_M0),
        .RID_M0(RID_M0), .RDATA_M0(RDATA_M0), .RRESP_M0(RRESP_M0), .RLAST_M0(RLAST_M0),
        .RVALID_M0(RVALID_M0), .RREADY_M0(RREADY_M0),
        .ARID_M1(ARID_M1), .ARADDR_M1(ARADDR_M1), .ARLEN_M1(ARLEN_M1),
        .ARSIZE_M1(ARSIZE_M1), .ARBURST_M1(ARBURST_M1), .ARVALID_M1(ARVALID_M1),
        .ARREADY_M1(ARREADY_M1),
        .RID_M1(RID_M1), .RDATA_M1(RDATA_M1), .RRESP_M1(RRESP_M1), .RLAST_M1(RLAST_M1),
        .RVALID_M1(RVALID_M1), .RREADY_M1(RREADY_M1),
        .ARID_S(ARID_S), .ARADDR_S(ARADDR_S), .ARLEN_S(ARLEN_S), .ARSIZE_S(ARSIZE_S),
        .ARBURST_S(ARBURST_S), .ARVALID_S(ARVALID_S), .ARREADY_S(ARREADY_S),
        .RID_S(RID_S), .RDATA_S(RDATA_S), .RRESP_S(RRESP_S), .RLAST_S(RLAST_S),
        .RVALID_S(RVALID_S), .RREADY_S(RREADY_S)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Scoreboard: every accepted beat on either master is popped and compared.
    always @(negedge clk) begin
        beat_t obs;
        beat_t exp_b;
        if (RVALID_M0 && RVALID_M1) begin
            checks++;
            errors++;
            $display("FAIL both_rvalid: RVALID_M0=%b RVALID_M1=%b, required at most one", RVALID_M0, RVALID_M1);
        end else if ((RVALID_M0 && RREADY_M0) || (RVALID_M1 && RREADY_M1)) begin
            if (RVALID_M1) obs = '{1'b1, RDATA_M1, RID_M1, RRESP_M1, RLAST_M1};
            else           obs = '{1'b0, RDATA_M0, RID_M0, RRESP_M0, RLAST_M0};
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_beat: got %h, scoreboard empty", obs);
            end else begin
                exp_b = q.pop_front();
                if (obs !== exp_b) begin
                    errors++;
                    $display("FAIL r_beat: got m=%0d data=%h id=%h resp=%b last=%b, required m=%0d data=%h id=%h resp=%b last=%b",
                             obs.m, obs.data, obs.id, obs.resp, obs.last,
                             exp_b.m, exp_b.data, exp_b.id, exp_b.resp, exp_b.last);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ARID_M0 = '0; ARADDR_M0 = '0; ARLEN_M0 = '0; ARSIZE_M0 = 3'd2; ARBURST_M0 = 2'b01; ARVALID_M0 = 1'b0;
        ARID_M1 = '0; ARADDR_M1 = '0; ARLEN_M1 = '0; ARSIZE_M1 = 3'd2; ARBURST_M1 = 2'b01; ARVALID_M1 = 1'b0;
        RREADY_M0 = 1'b0; RREADY_M1 = 1'b0;
        ARREADY_S = 1'b0; RID_S = '0; RDATA_S = '0; RRESP_S = 2'b00; RLAST_S = 1'b0; RVALID_S = 1'b0;
    endtask

    task automatic do_reset();
        cyc();
        clear_inputs();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        ARVALID_M0 = 1'b1; ARVALID_M1 = 1'b1; RVALID_S = 1'b1; RLAST_S = 1'b1;
        RREADY_M0 = 1'b1; RREADY_M1 = 1'b1; ARREADY_S = 1'b1;
        @(negedge clk);
        checks++; if (ARREADY_M0 !== 1'b0) begin errors++; $display("FAIL rst_arready_m0: got %b required 0", ARREADY_M0); end
        checks++; if (ARREADY_M1 !== 1'b0) begin errors++; $display("FAIL rst_arready_m1: got %b required 0", ARREADY_M1); end
        checks++; if (ARVALID_S !== 1'b0) begin errors++; $display("FAIL rst_arvalid_s: got %b required 0", ARVALID_S); end
        checks++; if (RREADY_S !== 1'b0) begin errors++; $display("FAIL rst_rready_s: got %b required 0", RREADY_S); end
        checks++; if (RVALID_M0 !== 1'b0 || RVALID_M1 !== 1'b0) begin errors++; $display("FAIL rst_rvalid: got %b%b required 00", RVALID_M0, RVALID_M1); end
        checks++; if (ARADDR_S !== 32'h0 || ARID_S !== 8'h00) begin errors++; $display("FAIL rst_fields: got addr=%h id=%h required 0", ARADDR_S, ARID_S); end
        do_reset();
    endtask

    task automatic test_single_m0();
        ARVALID_M0 = 1'b1; ARADDR_M0 = 32'h100; ARID_M0 = 4'd3; ARLEN_M0 = 4'd0;
        @(negedge clk);
        checks++; if (ARREADY_M0 !== 1'b1 || ARREADY_M1 !== 1'b0) begin errors++; $display("FAIL single_grant: got %b%b required 10", ARREADY_M0, ARREADY_M1); end
        checks++; if (ARVALID_S !== 1'b0) begin errors++; $display("FAIL single_arvalid_early: got %b required 0", ARVALID_S); end
        cyc();
        ARVALID_M0 = 1'b0; ARREADY_S = 1'b1;
        @(negedge clk);
        checks++; if (ARVALID_S !== 1'b1) begin errors++; $display("FAIL single_arvalid: got %b required 1", ARVALID_S); end
        checks++; if (ARID_S !== 8'h03 || ARADDR_S !== 32'h100 || ARLEN_S !== 4'd0) begin errors++; $display("FAIL single_ar_fields: got id=%h addr=%h len=%h required 03 100 0", ARID_S, ARADDR_S, ARLEN_S); end
        cyc();
        ARREADY_S = 1'b0; RVALID_S = 1'b1; RDATA_S = 32'hDEAD_0001; RID_S = 8'h03; RLAST_S = 1'b1; RRESP_S = 2'b00; RREADY_M0 = 1'b1;
        q.push_back('{1'b0, 32'hDEAD_0001, 4'd3, 2'b00, 1'b1});
        @(negedge clk);
        checks++; if (RREADY_S !== 1'b1 || RVALID_M1 !== 1'b0) begin errors++; $display("FAIL single_r_route: got rready_s=%b rvalid_m1=%b required 1 0", RREADY_S, RVALID_M1); end
        cyc();
        RVALID_S = 1'b0; RREADY_M0 = 1'b0; RLAST_S = 1'b0;
        ARVALID_M0 = 1'b1; ARVALID_M1 = 1'b1;
        @(negedge clk);
        checks++; if (ARREADY_M0 !== 1'b0 || ARREADY_M1 !== 1'b1) begin errors++; $display("FAIL single_prio_after: got %b%b required 01", ARREADY_M0, ARREADY_M1); end
        do_reset();
    endtask

    task automatic test_simultaneous();
        ARVALID_M0 = 1'b1; ARID_M0 = 4'd1; ARADDR_M0 = 32'hA000;
        ARVALID_M1 = 1'b1; ARID_M1 = 4'd2; ARADDR_M1 = 32'hB000;
        @(negedge clk);
        checks++; if (ARREADY_M0 !== 1'b1 || ARREADY_M1 !== 1'b0) begin errors++; $display("FAIL sim_first_grant: got %b%b required 10", ARREADY_M0, ARREADY_M1); end
        cyc();
        ARVALID_M0 = 1'b0; ARREADY_S = 1'b1;
        @(negedge clk);
        checks++; if (ARID_S !== 8'h01 || ARADDR_S !== 32'hA000) begin errors++; $display("FAIL sim_m0_ar: got id=%h addr=%h required 01 A000", ARID_S, ARADDR_S); end
        checks++; if (ARREADY_M1 !== 1'b0) begin errors++; $display("FAIL sim_wait_addr: got %b required 0", ARREADY_M1); end
        cyc();
        ARREADY_S = 1'b0; RVALID_S = 1'b1; RDATA_S = 32'h1111_2222; RID_S = 8'h01; RLAST_S = 1'b1; RREADY_M0 = 1'b1;
        q.push_back('{1'b0, 32'h1111_2222, 4'd1, 2'b00, 1'b1});
        @(negedge clk);
        checks++; if (ARREADY_M1 !== 1'b0) begin errors++; $display("FAIL sim_wait_data: got %b required 0", ARREADY_M1); end
        cyc();
        RVALID_S = 1'b0; RLAST_S = 1'b0; RREADY_M0 = 1'b0;
        @(negedge clk);
        checks++; if (ARREADY_M1 !== 1'b1) begin errors++; $display("FAIL sim_second_grant: got %b required 1", ARREADY_M1); end
        cyc();
        ARVALID_M1 = 1'b0; ARREADY_S = 1'b1;
        @(negedge clk);
        checks++; if (ARVALID_S !== 1'b1 || ARID_S !== 8'h12 || ARADDR_S !== 32'hB000) begin errors++; $display("FAIL sim_m1_ar: got v=%b id=%h addr=%h required 1 12 B000", ARVALID_S, ARID_S, ARADDR_S); end
        cyc();
        ARREADY_S = 1'b0; RVALID_S = 1'b1; RDATA_S = 32'h3333_4444; RID_S = 8'h12; RLAST_S = 1'b1; RREADY_M1 = 1'b1;
        q.push_back('{1'b1, 32'h3333_4444, 4'd2, 2'b00, 1'b1});
        cyc();
        do_reset();
    endtask

    task automatic test_burst_toggle();
        int   beat = 0;
        int   n = 0;
        logic rr = 1'b0;
        ARVALID_M1 = 1'b1; ARID_M1 = 4'd7; ARADDR_M1 = 32'hC000; ARLEN_M1 = 4'd3;
        cyc();
        ARVALID_M1 = 1'b0; ARREADY_S = 1'b1;
        cyc();
        ARREADY_S = 1'b0; ARVALID_M0 = 1'b1;
        while (beat < 4 && n < 16) begin
            RREADY_M1 = rr; RVALID_S = 1'b1; RDATA_S = 32'hB000_0000 + 32'(beat);
            RID_S = 8'h17; RLAST_S = (beat == 3); RRESP_S = 2'b00;
            if (rr) q.push_back('{1'b1, RDATA_S, 4'd7, 2'b00, RLAST_S});
            @(negedge clk);
            checks++; if (RREADY_S !== RREADY_M1) begin errors++; $display("FAIL burst_rready_mirror: got %b required %b", RREADY_S, RREADY_M1); end
            checks++; if (RVALID_M0 !== 1'b0 || ARREADY_M0 !== 1'b0) begin errors++; $display("FAIL burst_m0_quiet: got rvalid=%b arready=%b required 0 0", RVALID_M0, ARREADY_M0); end
            cyc();
            if (rr) beat++;
            rr = !rr;
            n++;
        end
        RVALID_S = 1'b0; RLAST_S = 1'b0; RREADY_M1 = 1'b0;
        checks++; if (beat != 4) begin errors++; $display("FAIL burst_beats: got %0d required 4", beat); end
        @(negedge clk);
        checks++; if (ARREADY_M0 !== 1'b1) begin errors++; $display("FAIL burst_idle_after: got %b required 1", ARREADY_M0); end
        do_reset();
    endtask

    task automatic test_arready_stall();
        ARVALID_M0 = 1'b1; ARADDR_M0 = 32'h200; ARID_M0 = 4'd4;
        cyc();
        ARADDR_M0 = 32'hFFFF_0000; ARVALID_M1 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (ARVALID_S !== 1'b1 || ARADDR_S !== 32'h200) begin errors++; $display("FAIL stall_ar_stable: got v=%b addr=%h required 1 200", ARVALID_S, ARADDR_S); end
            checks++; if (ARREADY_M0 !== 1'b0 || ARREADY_M1 !== 1'b0) begin errors++; $display("FAIL stall_arready: got %b%b required 00", ARREADY_M0, ARREADY_M1); end
            cyc();
        end
        do_reset();
    endtask

    task automatic test_decerr();
        ARVALID_M0 = 1'b1; ARID_M0 = 4'd5; ARADDR_M0 = 32'h300;
        cyc();
        ARVALID_M0 = 1'b0; ARREADY_S = 1'b1;
        cyc();
        ARREADY_S = 1'b0; RVALID_S = 1'b1; RID_S = 8'h15; RDATA_S = 32'h5555_AAAA; RRESP_S = 2'b00; RLAST_S = 1'b1; RREADY_M0 = 1'b1;
        q.push_back('{1'b0, 32'h5555_AAAA, 4'd5, 2'b11, 1'b1});
        @(negedge clk);
        checks++; if (RVALID_M1 !== 1'b0 || RID_M1 !== 4'd0) begin errors++; $display("FAIL decerr_m1_quiet: got v=%b id=%h required 0 0", RVALID_M1, RID_M1); end
        cyc();
        do_reset();
    endtask

    task automatic test_reset_mid_burst();
        ARVALID_M1 = 1'b1; ARID_M1 = 4'd9; ARADDR_M1 = 32'hD000; ARLEN_M1 = 4'd3;
        cyc();
        ARVALID_M1 = 1'b0; ARREADY_S = 1'b1;
        cyc();
        ARREADY_S = 1'b0; RVALID_S = 1'b1; RID_S = 8'h19; RDATA_S = 32'hD0; RREADY_M1 = 1'b1;
        q.push_back('{1'b1, 32'hD0, 4'd9, 2'b00, 1'b0});
        cyc();
        RDATA_S = 32'hD1;
        rst = 1'b1;
        #1;
        checks++; if (RVALID_M1 !== 1'b0 || RREADY_S !== 1'b0 || ARVALID_S !== 1'b0) begin errors++; $display("FAIL midrst_outputs: got rvalid=%b rready_s=%b arvalid_s=%b required 000", RVALID_M1, RREADY_S, ARVALID_S); end
        checks++; if (ARREADY_M0 !== 1'b0 || ARREADY_M1 !== 1'b0) begin errors++; $display("FAIL midrst_arready: got %b%b required 00", ARREADY_M0, ARREADY_M1); end
        cyc();
        clear_inputs();
        cyc();
        rst = 1'b0;
        ARVALID_M0 = 1'b1; ARID_M0 = 4'd2; ARVALID_M1 = 1'b1; ARID_M1 = 4'd6;
        @(negedge clk);
        checks++; if (ARREADY_M0 !== 1'b1 || ARREADY_M1 !== 1'b0) begin errors++; $display("FAIL midrst_regrant: got %b%b required 10", ARREADY_M0, ARREADY_M1); end
        cyc();
        ARVALID_M0 = 1'b0;
        @(negedge clk);
        checks++; if (ARVALID_S !== 1'b1 || ARID_S !== 8'h02) begin errors++; $display("FAIL midrst_ar: got v=%b id=%h required 1 02", ARVALID_S, ARID_S); end
        do_reset();
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_single_m0();
        test_simultaneous();
        test_burst_toggle();
        test_arready_stall();
        test_decerr();
        test_reset_mid_burst();
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending beats required 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
